// File: rtl/csr_trap_unit_pkg.sv
// Shared types, CSR addresses and WARL masks for the machine-mode CSR file and trap responder.
package csr_trap_unit_pkg;

    localparam int          MSTATUS_MIE_BIT     = 3;
    localparam int          MSTATUS_MPIE_BIT    = 7;
    localparam logic [31:0] MIE_MIP_WR_MASK     = 32'h0000_0888;
    localparam logic [31:0] MSTATUS_WR_MASK     = 32'h0000_0088;
    localparam logic        MTVEC_MODE_VECTORED = 1'b1;
    localparam logic [31:0] MSTATUS_RESET       = 32'h0000_1800;

    localparam logic [30:0] TRAP_CODE_ILLEGAL_INSTR = 31'd2;
    localparam logic [30:0] TRAP_CODE_ECALL_M_MODE  = 31'd11;

    localparam logic [11:0] CSR_MSTATUS    = 12'h300;
    localparam logic [11:0] CSR_MISA       = 12'h301;
    localparam logic [11:0] CSR_MIE        = 12'h304;
    localparam logic [11:0] CSR_MTVEC      = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH   = 12'h340;
    localparam logic [11:0] CSR_MEPC       = 12'h341;
    localparam logic [11:0] CSR_MCAUSE     = 12'h342;
    localparam logic [11:0] CSR_MTVAL      = 12'h343;
    localparam logic [11:0] CSR_MIP        = 12'h344;
    localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID  = 12'hF11;
    localparam logic [11:0] CSR_MARCHID    = 12'hF12;
    localparam logic [11:0] CSR_MIMPID     = 12'hF13;
    localparam logic [11:0] CSR_MHARTID    = 12'hF14;
    localparam logic [11:0] CSR_MCONFIGPTR = 12'hF15;

    typedef enum logic [1:0] {
        CSR_WRITE_DISABLE   = 2'd0,
        CSR_WRITE_RAW_VALUE = 2'd1,
        CSR_SET_BIT_MASK    = 2'd2,
        CSR_CLEAR_BIT_MASK  = 2'd3
    } csr_wr_type_e;

    typedef struct packed {
        logic        valid;
        logic        is_interrupt;
        logic [30:0] cause;
        logic [31:0] pc;
    } trap_info_t;

    // Zicsr read-modify-write: the old value is what the instruction reads back.
    function automatic logic [31:0] csr_apply_op(input logic [31:0] old_val,
                                                 input logic [31:0] operand,
                                                 input logic [1:0]  wr_type);
        case (wr_type)
            CSR_WRITE_RAW_VALUE: return operand;
            CSR_SET_BIT_MASK:    return old_val | operand;
            CSR_CLEAR_BIT_MASK:  return old_val & ~operand;
            default:             return old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_trap_unit_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves (mcycle / minstret).
module csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [31:0] lo_q;
    logic [31:0] hi_q;
    logic        carry;

    // A write to the low half replaces the increment, so it must not ripple into the high half.
    assign carry = inc_i && !wr_lo_i && (lo_q == 32'hFFFF_FFFF);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            if (wr_lo_i) begin
                lo_q <= wdata_i;
            end else if (inc_i) begin
                lo_q <= lo_q + 32'd1;
            end
            if (wr_hi_i) begin
                hi_q <= wdata_i;
            end else if (carry) begin
                hi_q <= hi_q + 32'd1;
            end
        end
    end

    assign count_o = {hi_q, lo_q};

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap responder: commits trap state, serves Zicsr accesses,
// keeps mcycle/minstret and produces a registered one-cycle fetch redirect.
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  trap_info_t  trap_i,
    input  logic [31:0] trap_mtval_i,
    input  logic        mret_i,
    input  logic        retire_i,
    input  logic [11:0] csr_addr_i,
    input  logic        csr_rd_en_i,
    input  logic [1:0]  csr_wr_type_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_illegal_o,
    input  logic        irq_sw_i,
    input  logic        irq_timer_i,
    input  logic        irq_ext_i,
    output logic        irq_pending_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);

    logic [31:0] mstatus_q;
    logic [31:0] mie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic [31:0] mip;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic [31:0] rdata;
    logic        known;
    logic        read_only;
    logic        wr_req;
    logic        wr_en;
    logic [31:0] wval;
    logic        flow_change;
    logic [31:0] trap_target;
    logic [31:0] vec_offset;

    assign mip = {20'b0, irq_ext_i, 3'b0, irq_timer_i, 3'b0, irq_sw_i, 3'b0};

    always_comb begin
        rdata     = '0;
        known     = 1'b1;
        read_only = 1'b0;
        case (csr_addr_i)
            CSR_MSTATUS:   rdata = mstatus_q;
            CSR_MISA:      rdata = MISA_VALUE;
            CSR_MIE:       rdata = mie_q;
            CSR_MTVEC:     rdata = mtvec_q;
            CSR_MSCRATCH:  rdata = mscratch_q;
            CSR_MEPC:      rdata = mepc_q;
            CSR_MCAUSE:    rdata = mcause_q;
            CSR_MTVAL:     rdata = mtval_q;
            CSR_MIP:       rdata = mip;
            CSR_MCYCLE:    rdata = mcycle[31:0];
            CSR_MCYCLEH:   rdata = mcycle[63:32];
            CSR_MINSTRET:  rdata = minstret[31:0];
            CSR_MINSTRETH: rdata = minstret[63:32];
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MCONFIGPTR: read_only = 1'b1;
            CSR_MHARTID: begin
                rdata     = HART_ID;
                read_only = 1'b1;
            end
            default:       known = 1'b0;
        endcase
    end

    assign csr_rdata_o   = rdata;
    assign wr_req        = (csr_wr_type_i != CSR_WRITE_DISABLE);
    assign csr_illegal_o = (!known && (csr_rd_en_i || wr_req)) || (read_only && wr_req);

    // Trap and MRET both own the cycle; any CSR write riding alongside is dropped.
    assign flow_change = trap_i.valid || mret_i;
    assign wr_en       = wr_req && !csr_illegal_o && !flow_change;
    assign wval        = csr_apply_op(rdata, csr_wdata_i, csr_wr_type_i);

    assign vec_offset  = (mtvec_q[0] == MTVEC_MODE_VECTORED && trap_i.is_interrupt)
                         ? {trap_i.cause[29:0], 2'b00} : 32'h0;
    assign trap_target = {mtvec_q[31:2], 2'b00} + vec_offset;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mstatus_q  <= MSTATUS_RESET;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (trap_i.valid) begin
            mepc_q                      <= {trap_i.pc[31:2], 2'b00};
            mcause_q                    <= {trap_i.is_interrupt, trap_i.cause};
            mtval_q                     <= trap_mtval_i;
            mstatus_q[MSTATUS_MPIE_BIT] <= mstatus_q[MSTATUS_MIE_BIT];
            mstatus_q[MSTATUS_MIE_BIT]  <= 1'b0;
        end else if (mret_i) begin
            mstatus_q[MSTATUS_MIE_BIT]  <= mstatus_q[MSTATUS_MPIE_BIT];
            mstatus_q[MSTATUS_MPIE_BIT] <= 1'b1;
        end else if (wr_en) begin
            case (csr_addr_i)
                CSR_MSTATUS:  mstatus_q  <= (mstatus_q & ~MSTATUS_WR_MASK) | (wval & MSTATUS_WR_MASK);
                CSR_MIE:      mie_q      <= wval & MIE_MIP_WR_MASK;
                CSR_MTVEC:    mtvec_q    <= {wval[31:2], 1'b0, wval[0]};
                CSR_MSCRATCH: mscratch_q <= wval;
                CSR_MEPC:     mepc_q     <= {wval[31:2], 2'b00};
                CSR_MCAUSE:   mcause_q   <= wval;
                CSR_MTVAL:    mtval_q    <= wval;
                default:      ;
            endcase
        end
    end

    // redirect_valid_o is a valid-only pulse with no ready: fetch must take redirect_pc_o
    // in the cycle the pulse is high; the pc holds its last target otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            redirect_valid_o <= flow_change;
            if (trap_i.valid) begin
                redirect_pc_o <= trap_target;
            end else if (mret_i) begin
                redirect_pc_o <= mepc_q;
            end
        end
    end

    assign irq_pending_o = mstatus_q[MSTATUS_MIE_BIT] && |(mie_q & mip);

    csr_counter64 u_mcycle (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (1'b1),
        .wr_lo_i (wr_en && (csr_addr_i == CSR_MCYCLE)),
        .wr_hi_i (wr_en && (csr_addr_i == CSR_MCYCLEH)),
        .wdata_i (wval),
        .count_o (mcycle)
    );

    csr_counter64 u_minstret (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (retire_i && !flow_change),
        .wr_lo_i (wr_en && (csr_addr_i == CSR_MINSTRET)),
        .wr_hi_i (wr_en && (csr_addr_i == CSR_MINSTRETH)),
        .wdata_i (wval),
        .count_o (minstret)
    );

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed feature tests plus a randomized run against a field-level model of the CSR file.
module tb_csr_trap_unit;
  import csr_trap_unit_pkg::*;

  localparam logic [31:0] MISA_V = 32'h4000_0100;
  localparam logic [31:0] HART_V = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  trap_info_t  trap;
  logic [31:0] trap_mtval;
  logic        mret;
  logic        retire;
  logic [11:0] csr_addr;
  logic        csr_rd_en;
  logic [1:0]  csr_wr_type;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        irq_sw;
  logic        irq_timer;
  logic        irq_ext;
  logic        irq_pending;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // reference model: architectural fields, not register words
  logic        m_mie;
  logic        m_mpie;
  logic [31:0] m_mie_reg;
  logic [31:0] m_mtvec;
  logic [31:0] m_mscratch;
  logic [31:0] m_mepc;
  logic [31:0] m_mcause;
  logic [31:0] m_mtval;

  csr_trap_unit #(
    .MTVEC_RESET (32'h0),
    .MISA_VALUE  (MISA_V),
    .HART_ID     (HART_V)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .trap_i           (trap),
    .trap_mtval_i     (trap_mtval),
    .mret_i           (mret),
    .retire_i         (retire),
    .csr_addr_i       (csr_addr),
    .csr_rd_en_i      (csr_rd_en),
    .csr_wr_type_i    (csr_wr_type),
    .csr_wdata_i      (csr_wdata),
    .csr_rdata_o      (csr_rdata),
    .csr_illegal_o    (csr_illegal),
    .irq_sw_i         (irq_sw),
    .irq_timer_i      (irq_timer),
    .irq_ext_i        (irq_ext),
    .irq_pending_o    (irq_pending),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // drivers
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    trap        = '0;
    trap_mtval  = '0;
    mret        = 1'b0;
    retire      = 1'b0;
    csr_addr    = '0;
    csr_rd_en   = 1'b0;
    csr_wr_type = CSR_WRITE_DISABLE;
    csr_wdata   = '0;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] data);
    csr_addr    = addr;
    csr_wr_type = op;
    csr_wdata   = data;
    tick();
    csr_wr_type = CSR_WRITE_DISABLE;
  endtask

  task automatic csr_read(input logic [11:0] addr, output logic [31:0] data, output logic ill);
    csr_addr    = addr;
    csr_rd_en   = 1'b1;
    csr_wr_type = CSR_WRITE_DISABLE;
    #1;
    data      = csr_rdata;
    ill       = csr_illegal;
    csr_rd_en = 1'b0;
  endtask

  task automatic drive_trap(input logic is_int, input logic [30:0] cause, input logic [31:0] pc,
                            input logic [31:0] tval);
    trap.valid        = 1'b1;
    trap.is_interrupt = is_int;
    trap.cause        = cause;
    trap.pc           = pc;
    trap_mtval        = tval;
  endtask

  // model helpers
  task automatic model_reset();
    m_mie = 1'b0; m_mpie = 1'b0; m_mie_reg = '0; m_mtvec = '0;
    m_mscratch = '0; m_mepc = '0; m_mcause = '0; m_mtval = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS:  return 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
      CSR_MIE:      return m_mie_reg;
      CSR_MTVEC:    return m_mtvec;
      CSR_MSCRATCH: return m_mscratch;
      CSR_MEPC:     return m_mepc;
      CSR_MCAUSE:   return m_mcause;
      CSR_MTVAL:    return m_mtval;
      default:      return 32'h0;
    endcase
  endfunction

  task automatic m_write(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] d);
    logic [31:0] old_v;
    logic [31:0] new_v;
    old_v = m_read(addr);
    if (op == CSR_WRITE_DISABLE) return;
    new_v = (op == CSR_WRITE_RAW_VALUE) ? d : (op == CSR_SET_BIT_MASK) ? (old_v | d) : (old_v & ~d);
    case (addr)
      CSR_MSTATUS:  begin m_mie = new_v[3]; m_mpie = new_v[7]; end
      CSR_MIE:      m_mie_reg = new_v & 32'h888;
      CSR_MTVEC:    m_mtvec = new_v & ~32'h2;
      CSR_MSCRATCH: m_mscratch = new_v;
      CSR_MEPC:     m_mepc = new_v & ~32'h3;
      CSR_MCAUSE:   m_mcause = new_v;
      CSR_MTVAL:    m_mtval = new_v;
      default:      ;
    endcase
  endtask

  function automatic logic [11:0] pick_addr(input int i);
    case (i)
      0: return CSR_MSTATUS;
      1: return CSR_MIE;
      2: return CSR_MTVEC;
      3: return CSR_MSCRATCH;
      4: return CSR_MEPC;
      5: return CSR_MCAUSE;
      default: return CSR_MTVAL;
    endcase
  endfunction

  // tests
  task automatic test_reset();
    logic [31:0] d;
    logic        ill;
    rst_ni = 1'b0;
    idle_inputs();
    irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", redirect_valid); end
    n_vec++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=0", redirect_pc); end
    rst_ni = 1'b1;
    tick();
    csr_read(CSR_MSTATUS, d, ill);
    n_vec++; if (d !== 32'h1800) begin n_err++; $display("FAIL reset_mstatus got=%h exp=00001800", d); end
    csr_read(CSR_MISA, d, ill);
    n_vec++; if (d !== MISA_V || ill !== 1'b0) begin n_err++; $display("FAIL reset_misa got=%h/%b exp=%h/0", d, ill, MISA_V); end
    csr_read(CSR_MHARTID, d, ill);
    n_vec++; if (d !== HART_V || ill !== 1'b0) begin n_err++; $display("FAIL reset_mhartid got=%h/%b exp=%h/0", d, ill, HART_V); end
    csr_read(CSR_MTVEC, d, ill);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_mtvec got=%h exp=0", d); end
    n_vec++; if (irq_pending !== 1'b0) begin n_err++; $display("FAIL reset_irq_pending got=%b exp=0", irq_pending); end
  endtask

  task automatic test_sync_trap();
    logic [31:0] d;
    logic        ill;
    csr_write(CSR_MTVEC, CSR_WRITE_RAW_VALUE, 32'h100);
    drive_trap(1'b0, TRAP_CODE_ECALL_M_MODE, 32'h2002, 32'h0);
    tick();
    trap = '0;
    n_vec++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin
      n_err++; $display("FAIL ecall_redirect got=%b/%h exp=1/00000100", redirect_valid, redirect_pc); end
    csr_read(CSR_MEPC, d, ill);
    n_vec++; if (d !== 32'h2000) begin n_err++; $display("FAIL ecall_mepc got=%h exp=00002000", d); end
    csr_read(CSR_MCAUSE, d, ill);
    n_vec++; if (d !== 32'd11) begin n_err++; $display("FAIL ecall_mcause got=%h exp=0000000b", d); end
    tick();
    n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL ecall_pulse_width got=%b exp=0", redirect_valid); end
  endtask

  task automatic test_irq_trap();
    logic [31:0] d;
    logic        ill;
    csr_write(CSR_MTVEC, CSR_WRITE_RAW_VALUE, 32'h101);
    csr_write(CSR_MIE, CSR_WRITE_RAW_VALUE, 32'h80);
    csr_write(CSR_MSTATUS, CSR_SET_BIT_MASK, 32'h8);
    irq_timer = 1'b1;
    #1;
    n_vec++; if (irq_pending !== 1'b1) begin n_err++; $display("FAIL irq_pending_set got=%b exp=1", irq_pending); end
    drive_trap(1'b1, 31'd7, 32'h3000, 32'h0);
    tick();
    trap = '0;
    n_vec++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h11C) begin
      n_err++; $display("FAIL irq_vectored_pc got=%b/%h exp=1/0000011c", redirect_valid, redirect_pc); end
    csr_read(CSR_MSTATUS, d, ill);
    n_vec++; if (d !== 32'h1880) begin n_err++; $display("FAIL irq_mstatus got=%h exp=00001880", d); end
    csr_read(CSR_MCAUSE, d, ill);
    n_vec++; if (d !== 32'h8000_0007) begin n_err++; $display("FAIL irq_mcause got=%h exp=80000007", d); end
    n_vec++; if (irq_pending !== 1'b0) begin n_err++; $display("FAIL irq_pending_masked got=%b exp=0", irq_pending); end
    tick();
  endtask

  task automatic test_mret();
    logic [31:0] d;
    logic        ill;
    csr_write(CSR_MSCRATCH, CSR_WRITE_RAW_VALUE, 32'h55);
    mret        = 1'b1;
    csr_addr    = CSR_MSCRATCH;
    csr_wr_type = CSR_WRITE_RAW_VALUE;
    csr_wdata   = 32'hDEAD_BEEF;
    tick();
    mret        = 1'b0;
    csr_wr_type = CSR_WRITE_DISABLE;
    n_vec++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h3000) begin
      n_err++; $display("FAIL mret_redirect got=%b/%h exp=1/00003000", redirect_valid, redirect_pc); end
    csr_read(CSR_MSTATUS, d, ill);
    n_vec++; if (d !== 32'h1888) begin n_err++; $display("FAIL mret_mstatus got=%h exp=00001888", d); end
    csr_read(CSR_MSCRATCH, d, ill);
    n_vec++; if (d !== 32'h55) begin n_err++; $display("FAIL mret_drops_write got=%h exp=00000055", d); end
    n_vec++; if (irq_pending !== 1'b1) begin n_err++; $display("FAIL mret_irq_pending got=%b exp=1", irq_pending); end
    tick();
    irq_timer = 1'b0;
  endtask

  task automatic test_illegal();
    logic [31:0] d;
    logic        ill;
    csr_addr = CSR_MVENDORID; csr_rd_en = 1'b1; csr_wr_type = CSR_WRITE_RAW_VALUE; csr_wdata = 32'h1;
    #1;
    n_vec++; if (csr_illegal !== 1'b1) begin n_err++; $display("FAIL csrrw_mvendorid got=%b exp=1", csr_illegal); end
    tick();
    csr_wr_type = CSR_WRITE_DISABLE;
    csr_read(CSR_MVENDORID, d, ill);
    n_vec++; if (ill !== 1'b0 || d !== 32'h0) begin n_err++; $display("FAIL csrrs_x0_mvendorid got=%b/%h exp=0/0", ill, d); end
    csr_read(12'h7C0, d, ill);
    n_vec++; if (ill !== 1'b1 || d !== 32'h0) begin n_err++; $display("FAIL read_unmapped got=%b/%h exp=1/0", ill, d); end
    csr_addr = 12'h7C0; csr_wr_type = CSR_SET_BIT_MASK;
    #1;
    n_vec++; if (csr_illegal !== 1'b1) begin n_err++; $display("FAIL write_unmapped got=%b exp=1", csr_illegal); end
    csr_addr = CSR_MHARTID; csr_wr_type = CSR_CLEAR_BIT_MASK;
    #1;
    n_vec++; if (csr_illegal !== 1'b1) begin n_err++; $display("FAIL clear_mhartid got=%b exp=1", csr_illegal); end
    csr_addr = CSR_MIP; csr_wr_type = CSR_WRITE_RAW_VALUE; csr_wdata = 32'hFFFF_FFFF;
    #1;
    n_vec++; if (csr_illegal !== 1'b0) begin n_err++; $display("FAIL write_mip got=%b exp=0", csr_illegal); end
    csr_write(CSR_MISA, CSR_WRITE_RAW_VALUE, 32'h0);
    csr_read(CSR_MISA, d, ill);
    n_vec++; if (d !== MISA_V) begin n_err++; $display("FAIL misa_write_ignored got=%h exp=%h", d, MISA_V); end
    csr_read(CSR_MIP, d, ill);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL mip_follows_lines got=%h exp=0", d); end
  endtask

  task automatic test_warl();
    logic [31:0] d;
    logic        ill;
    csr_write(CSR_MSTATUS, CSR_WRITE_RAW_VALUE, 32'hFFFF_FFFF);
    csr_read(CSR_MSTATUS, d, ill);
    n_vec++; if (d !== 32'h1888) begin n_err++; $display("FAIL warl_mstatus got=%h exp=00001888", d); end
    csr_write(CSR_MSTATUS, CSR_CLEAR_BIT_MASK, 32'hFFFF_FFFF);
    csr_read(CSR_MSTATUS, d, ill);
    n_vec++; if (d !== 32'h1800) begin n_err++; $display("FAIL warl_mstatus_clear got=%h exp=00001800", d); end
    csr_write(CSR_MIE, CSR_WRITE_RAW_VALUE, 32'hFFFF_FFFF);
    csr_read(CSR_MIE, d, ill);
    n_vec++; if (d !== 32'h888) begin n_err++; $display("FAIL warl_mie got=%h exp=00000888", d); end
    csr_write(CSR_MEPC, CSR_WRITE_RAW_VALUE, 32'hFFFF_FFFF);
    csr_read(CSR_MEPC, d, ill);
    n_vec++; if (d !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL warl_mepc got=%h exp=fffffffc", d); end
    csr_write(CSR_MTVEC, CSR_WRITE_RAW_VALUE, 32'hFFFF_FFFF);
    csr_read(CSR_MTVEC, d, ill);
    n_vec++; if (d !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL warl_mtvec got=%h exp=fffffffd", d); end
    csr_write(CSR_MIE, CSR_WRITE_RAW_VALUE, 32'h0);
  endtask

  task automatic test_counters();
    logic [31:0] d;
    logic [31:0] h;
    logic        ill;
    csr_write(CSR_MCYCLEH, CSR_WRITE_RAW_VALUE, 32'h0);
    csr_write(CSR_MCYCLE, CSR_WRITE_RAW_VALUE, 32'hFFFF_FFFF);
    tick();
    csr_read(CSR_MCYCLE, d, ill);
    csr_read(CSR_MCYCLEH, h, ill);
    n_vec++; if (d !== 32'h0 || h !== 32'h1) begin n_err++; $display("FAIL mcycle_carry got=%h_%h exp=00000001_00000000", h, d); end
    csr_write(CSR_MCYCLE, CSR_WRITE_RAW_VALUE, 32'd5);
    csr_read(CSR_MCYCLE, d, ill);
    n_vec++; if (d !== 32'd5) begin n_err++; $display("FAIL mcycle_write_wins got=%h exp=00000005", d); end
    csr_write(CSR_MINSTRETH, CSR_WRITE_RAW_VALUE, 32'h0);
    csr_write(CSR_MINSTRET, CSR_WRITE_RAW_VALUE, 32'h0);
    retire = 1'b1;
    repeat (3) tick();
    drive_trap(1'b0, TRAP_CODE_ILLEGAL_INSTR, 32'h40, 32'h0);
    tick();
    trap = '0;
    retire = 1'b0;
    n_vec++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL direct_mode_trap got=%b/%h exp=1/fffffffc", redirect_valid, redirect_pc); end
    csr_read(CSR_MINSTRET, d, ill);
    n_vec++; if (d !== 32'd3) begin n_err++; $display("FAIL minstret_count got=%h exp=00000003", d); end
    csr_write(CSR_MINSTRETH, CSR_WRITE_RAW_VALUE, 32'hFFFF_FFFF);
    csr_write(CSR_MINSTRET, CSR_WRITE_RAW_VALUE, 32'hFFFF_FFFF);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    csr_read(CSR_MINSTRET, d, ill);
    csr_read(CSR_MINSTRETH, h, ill);
    n_vec++; if (d !== 32'h0 || h !== 32'h0) begin n_err++; $display("FAIL minstret_wrap got=%h_%h exp=0_0", h, d); end
    retire = 1'b1;
    csr_write(CSR_MINSTRET, CSR_WRITE_RAW_VALUE, 32'd7);
    retire = 1'b0;
    csr_read(CSR_MINSTRET, d, ill);
    n_vec++; if (d !== 32'd7) begin n_err++; $display("FAIL minstret_write_wins got=%h exp=00000007", d); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d;
    logic        ill;
    drive_trap(1'b0, TRAP_CODE_ECALL_M_MODE, 32'h5554, 32'h0);
    #2;
    rst_ni = 1'b0;
    #1;
    trap = '0;
    tick();
    n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL reset_drops_redirect got=%b exp=0", redirect_valid); end
    csr_read(CSR_MEPC, d, ill);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_mepc got=%h exp=0", d); end
    rst_ni = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      int          act;
      logic [11:0] a;
      logic [1:0]  op;
      logic [31:0] d;
      logic        is_int;
      logic [30:0] cause;
      logic [31:0] pc;
      logic [31:0] tval;
      logic [31:0] mip_v;
      act    = $urandom_range(0, 9);
      a      = pick_addr($urandom_range(0, 6));
      op     = 2'($urandom_range(0, 3));
      d      = $urandom;
      is_int = 1'($urandom_range(0, 1));
      cause  = is_int ? 31'(3 + 4 * $urandom_range(0, 2)) : 31'($urandom_range(0, 15));
      pc     = $urandom;
      tval   = $urandom;
      irq_sw    = 1'($urandom_range(0, 1));
      irq_timer = 1'($urandom_range(0, 1));
      irq_ext   = 1'($urandom_range(0, 1));
      retire    = 1'($urandom_range(0, 1));
      csr_addr    = a;
      csr_rd_en   = 1'b1;
      csr_wr_type = op;
      csr_wdata   = d;
      if (act < 2) drive_trap(is_int, cause, pc, tval);
      mret = (act == 2);
      #1;
      n_vec++; if (csr_rdata !== m_read(a) || csr_illegal !== 1'b0) begin
        n_err++; $display("FAIL rand_read it=%0d addr=%h got=%h/%b exp=%h/0", it, a, csr_rdata, csr_illegal, m_read(a)); end
      if (act < 2) begin
        exp_q.push_back((m_mtvec & ~32'h3) + (((m_mtvec & 32'h1) != 0 && is_int) ? 32'(cause) * 4 : 32'h0));
        m_mepc   = pc & ~32'h3;
        m_mcause = {is_int, cause};
        m_mtval  = tval;
        m_mpie   = m_mie;
        m_mie    = 1'b0;
      end else if (act == 2) begin
        exp_q.push_back(m_mepc);
        m_mie  = m_mpie;
        m_mpie = 1'b1;
      end else begin
        m_write(a, op, d);
      end
      tick();
      trap = '0;
      mret = 1'b0;
      csr_wr_type = CSR_WRITE_DISABLE;
      csr_rd_en = 1'b0;
      if (exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        n_vec++; if (redirect_valid !== 1'b1 || redirect_pc !== e) begin
          n_err++; $display("FAIL rand_redirect it=%0d got=%b/%h exp=1/%h", it, redirect_valid, redirect_pc, e); end
      end else begin
        n_vec++; if (redirect_valid !== 1'b0) begin
          n_err++; $display("FAIL rand_no_redirect it=%0d got=%b exp=0", it, redirect_valid); end
      end
      mip_v = (irq_sw ? 32'h8 : 32'h0) | (irq_timer ? 32'h80 : 32'h0) | (irq_ext ? 32'h800 : 32'h0);
      n_vec++; if (irq_pending !== (m_mie && ((m_mie_reg & mip_v) != 0))) begin
        n_err++; $display("FAIL rand_irq_pending it=%0d got=%b exp=%b", it, irq_pending, (m_mie && ((m_mie_reg & mip_v) != 0))); end
    end
    retire = 1'b0;
  endtask

  // final report
  initial begin
    test_reset();
    test_sync_trap();
    test_irq_trap();
    test_mret();
    test_illegal();
    test_warl();
    test_counters();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
